// File: rtl/ir_frame_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ir_frame_decoder : IR remote frame receiver with colour-counter capture.
// Optional build macro IR_MAJORITY_EN enables 3-sample voting.  Rev 1.0
// ---------------------------------------------------------------------------
module ir_frame_decoder #(
  parameter int                    NBITS        = 3,
  parameter int                    FIRST_SAMPLE = 193,
  parameter int                    BIT_TICKS    = 41,
  parameter int                    READY_CYCLES = 4,
  parameter int                    REARM_TICKS  = 64,
  parameter int                    COLOR_W      = 2,
  parameter logic [(1<<NBITS)-1:0] VALID_MASK   = 8'h5E
) (
  input  logic               clk_pll,
  input  logic               reset,
  input  logic               IRDA_RXD,
  output logic [NBITS-1:0]   botao,
  output logic               ready,
  output logic               frame_err,
  output logic [COLOR_W-1:0] cor,
  output logic               busy
);

  localparam int c_max_a = (FIRST_SAMPLE > BIT_TICKS) ? FIRST_SAMPLE : BIT_TICKS;
  localparam int c_max_b = (REARM_TICKS > READY_CYCLES) ? REARM_TICKS : READY_CYCLES;
  localparam int c_max_t = (c_max_a > c_max_b) ? c_max_a : c_max_b;
  localparam int c_cnt_w = $clog2(c_max_t) + 1;
  localparam int c_idx_w = $clog2(NBITS) + 1;

  localparam logic [c_cnt_w-1:0] c_first_ld   = c_cnt_w'(FIRST_SAMPLE - 1);
  localparam logic [c_cnt_w-1:0] c_bit_ld     = c_cnt_w'(BIT_TICKS - 1);
  localparam logic [c_cnt_w-1:0] c_ready_ld   = c_cnt_w'(READY_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_rearm_last = c_cnt_w'(REARM_TICKS - 1);
  localparam logic [c_idx_w-1:0] c_last_idx   = c_idx_w'(NBITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACQ   = 3'd1,
    ST_CHECK = 3'd2,
    ST_HOLD  = 3'd3,
    ST_REARM = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic                 rxd_s;
  logic                 bit_s;
  logic                 start_s;
  logic [COLOR_W-1:0]   color_q;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [c_cnt_w-1:0]   idle_q, idle_d;
  logic [c_idx_w-1:0]   idx_q, idx_d;
  logic [NBITS-1:0]     shreg_q, shreg_d;
  logic [NBITS-1:0]     botao_q, botao_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;
  logic [COLOR_W-1:0]   cor_q, cor_d;

  // Synchroniser resets to the idle-high level so reset release never looks like a start.
  always_ff @(posedge clk_pll) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], IRDA_RXD};
    end
  end

  assign rxd_s = sync_q[1];

`ifdef IR_MAJORITY_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk_pll) begin
    if (reset) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rxd_s};
    end
  end

  assign bit_s   = (rxd_s & hist_q[0]) | (rxd_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
  assign start_s = ~rxd_s & hist_q[0] & hist_q[1];
`else
  assign bit_s   = rxd_s;
  assign start_s = ~rxd_s;
`endif

  always_ff @(posedge clk_pll) begin
    if (reset) begin
      state_q <= ST_IDLE;
      color_q <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      botao_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      cor_q   <= '0;
    end else begin
      state_q <= state_d;
      color_q <= color_q + 1'b1;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      botao_q <= botao_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      cor_q   <= cor_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    botao_d = botao_q;
    ready_d = ready_q;
    err_d   = 1'b0;
    cor_d   = cor_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          cnt_d   = c_first_ld;
          idx_d   = '0;
          cor_d   = color_q;
          state_d = ST_ACQ;
        end
      end
      ST_ACQ: begin
        // Line level between sample points is deliberately ignored.
        if (cnt_q == '0) begin
          shreg_d = (shreg_q << 1) | NBITS'(bit_s);
          cnt_d   = c_bit_ld;
          idx_d   = idx_q + 1'b1;
          if (idx_q == c_last_idx) begin
            state_d = ST_CHECK;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_CHECK: begin
        idle_d = '0;
        if (VALID_MASK[shreg_q]) begin
          botao_d = shreg_q;
          ready_d = 1'b1;
          cnt_d   = c_ready_ld;
          state_d = ST_HOLD;
        end else begin
          err_d   = 1'b1;
          state_d = ST_REARM;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          ready_d = 1'b0;
          idle_d  = '0;
          state_d = ST_REARM;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_REARM: begin
        if (!rxd_s) begin
          idle_d = '0;
        end else if (idle_q == c_rearm_last) begin
          state_d = ST_IDLE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign botao     = botao_q;
  assign ready     = ready_q;
  assign frame_err = err_q;
  assign cor       = cor_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ir_frame_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ir_frame_decoder : randomized and directed frames against a timeline model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ir_frame_decoder;

  localparam int NB   = 3;
  localparam int FS   = 193;
  localparam int BT   = 41;
  localparam int RC   = 4;
  localparam int RT   = 64;
  localparam int CW   = 2;
  localparam logic [7:0] VM = 8'h5E;
  localparam int MAXC = 4000;

  logic          clk_pll  = 1'b0;
  logic          reset    = 1'b1;
  logic          IRDA_RXD = 1'b1;
  logic [NB-1:0] botao;
  logic          ready;
  logic          frame_err;
  logic [CW-1:0] cor;
  logic          busy;

  ir_frame_decoder #(
    .NBITS(NB), .FIRST_SAMPLE(FS), .BIT_TICKS(BT), .READY_CYCLES(RC),
    .REARM_TICKS(RT), .COLOR_W(CW), .VALID_MASK(VM)
  ) dut (
    .clk_pll(clk_pll), .reset(reset), .IRDA_RXD(IRDA_RXD), .botao(botao),
    .ready(ready), .frame_err(frame_err), .cor(cor), .busy(busy)
  );

  always #5 clk_pll = ~clk_pll;

  int n_tests = 0;
  int n_fail  = 0;

  bit            line    [MAXC];
  int            n_len;
  logic [NB-1:0] e_botao [MAXC];
  logic [CW-1:0] e_cor   [MAXC];
  bit            e_ready [MAXC];
  bit            e_err   [MAXC];
  bit            e_busy  [MAXC];
  logic [NB-1:0] o_botao [MAXC];
  logic [CW-1:0] o_cor   [MAXC];
  logic          o_ready [MAXC];
  logic          o_err   [MAXC];
  logic          o_busy  [MAXC];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Synchronised line level seen by the receiver in cycle c (cycle 0 = first cycle out of reset).
  function automatic bit rs(input int c);
    if (c < 2 || c - 2 >= n_len) return 1'b1;
    return line[c-2];
  endfunction

  function automatic bit sample_at(input int c);
`ifdef IR_MAJORITY_EN
    int ones;
    ones = int'(rs(c)) + int'(rs(c-1)) + int'(rs(c-2));
    return (ones >= 2);
`else
    return rs(c);
`endif
  endfunction

  function automatic bit start_at(input int c);
`ifdef IR_MAJORITY_EN
    return !rs(c) && rs(c-1) && rs(c-2);
`else
    return !rs(c);
`endif
  endfunction

  // Frame-level timeline: find start, read bits at fixed offsets, then lay out outputs.
  task automatic build_expected(input int len);
    int t, s, l, r0, run;
    logic [NB-1:0] code;
    for (int k = 0; k < len; k++) begin
      e_botao[k] = '0; e_cor[k] = '0; e_ready[k] = 1'b0; e_err[k] = 1'b0; e_busy[k] = 1'b0;
    end
    t = 0;
    while (t < len) begin
      if (!start_at(t)) begin
        t++;
        continue;
      end
      s = t;
      code = '0;
      for (int i = 0; i < NB; i++) code = (code << 1) | NB'(sample_at(s + FS + i*BT));
      l = s + FS + (NB-1)*BT;
      for (int k = s + 1; k < len; k++) e_cor[k] = CW'(s);
      if (VM[code]) begin
        for (int k = l + 2; k < len; k++) e_botao[k] = code;
        for (int k = l + 2; k <= l + 1 + RC && k < len; k++) e_ready[k] = 1'b1;
        r0 = l + 2 + RC;
      end else begin
        if (l + 2 < len) e_err[l+2] = 1'b1;
        r0 = l + 2;
      end
      run = 0;
      t = r0;
      while (t < len && run < RT) begin
        run = rs(t) ? run + 1 : 0;
        t++;
      end
      for (int k = s + 1; k < t && k < len; k++) e_busy[k] = 1'b1;
    end
  endtask

  task automatic clear_line();
    for (int j = 0; j < MAXC; j++) line[j] = 1'b1;
  endtask

  // Start burst low from p, then one BT-wide window per bit centred on its sample point.
  task automatic put_frame(input int p, input logic [NB-1:0] code, output int p_end);
    int stop;
    stop = p + FS + (NB-1)*BT + BT/2;
    for (int j = p; j <= stop; j++) line[j] = 1'b0;
    for (int i = 0; i < NB; i++)
      for (int j = -(BT/2); j <= BT/2; j++) line[p + FS + i*BT + j] = code[NB-1-i];
    p_end = stop + 1;
  endtask

  task automatic run_episode(input int len, input bit rst_at_end);
    n_len = len;
    build_expected(len);
    reset = 1'b1;
    IRDA_RXD = 1'b1;
    repeat (3) @(posedge clk_pll);
    #1;
    check_eq("reset_state", 32'({botao, ready, frame_err, cor, busy}), 32'h0);
    for (int c = 0; c < len; c++) begin
      o_botao[c] = botao; o_cor[c] = cor; o_ready[c] = ready; o_err[c] = frame_err; o_busy[c] = busy;
      check_eq($sformatf("cycle%0d", c), 32'({botao, ready, frame_err, cor, busy}),
               32'({e_botao[c], e_ready[c], e_err[c], e_cor[c], e_busy[c]}));
      reset = 1'b0;
      IRDA_RXD = line[c];
      @(posedge clk_pll);
      #1;
    end
    if (rst_at_end) begin
      reset = 1'b1;
      IRDA_RXD = 1'b1;
      @(posedge clk_pll);
      #1;
      check_eq("mid_reset", 32'({botao, ready, frame_err, cor, busy}), 32'h0);
    end
  endtask

  int p, q, pe, s1, s2, s3, nrdy, nfr, len, cut;
  logic [NB-1:0] rcode;

  initial begin
    // Valid 1,0,0 frame, long low + glitch during rearm, then invalid 1,1,1 frame.
    clear_line();
    p = 11; s1 = p + 2;
    put_frame(p, 3'b100, q);
    for (int j = q; j < q + 100; j++) line[j] = 1'b0;
    line[q + 130] = 1'b0;
    put_frame(q + 200, 3'b111, pe);
    s2 = q + 202;
    run_episode(s2 + 360, 1'b0);
    check_eq("t2_ready_pre",  32'(o_ready[s1+276]), 32'd0);
    for (int k = 277; k <= 280; k++) check_eq($sformatf("t2_ready_S+%0d", k), 32'(o_ready[s1+k]), 32'd1);
    check_eq("t2_ready_post", 32'(o_ready[s1+281]), 32'd0);
    check_eq("t2_botao",      32'(o_botao[s1+277]), 32'h4);
    check_eq("t2_err",        32'(o_err[s1+277]),   32'd0);
    check_eq("t2_cor",        32'(o_cor[s1+1]),     32'(CW'(s1)));
    check_eq("t4_busy_glitch", 32'(o_busy[q+160]), 32'd1);
    check_eq("t4_busy_last",   32'(o_busy[q+196]), 32'd1);
    check_eq("t4_idle",        32'(o_busy[q+197]), 32'd0);
    check_eq("t3_err_pre",  32'(o_err[s2+276]), 32'd0);
    check_eq("t3_err",      32'(o_err[s2+277]), 32'd1);
    check_eq("t3_err_post", 32'(o_err[s2+278]), 32'd0);
    check_eq("t3_ready",    32'(o_ready[s2+277]), 32'd0);
    check_eq("t3_botao",    32'(o_botao[s2+280]), 32'h4);
    check_eq("t3_cor",      32'(o_cor[s2+1]),     32'(CW'(s2)));

    // Reset in the middle of acquisition.
    clear_line();
    put_frame(11, 3'b110, pe);
    run_episode(13 + 200, 1'b1);

    // Clean 0,1,1 frame, then a low bit0 window with a one-cycle high at the sample point.
    clear_line();
    p = 11; s1 = p + 2;
    put_frame(p, 3'b011, q);
    p = q + 100; s3 = p + 2;
    put_frame(p, 3'b011, pe);
    line[p + FS] = 1'b1;
    run_episode(s3 + 360, 1'b0);
    nrdy = 0;
    for (int k = s1; k < s1 + 320; k++) nrdy += int'(o_ready[k]);
    check_eq("t5_ready_len", 32'(nrdy), 32'd4);
    check_eq("t5_botao",     32'(o_botao[s1+277]), 32'h3);
`ifdef IR_MAJORITY_EN
    check_eq("t6_err",   32'(o_err[s3+277]),   32'd0);
    check_eq("t6_ready", 32'(o_ready[s3+277]), 32'd1);
`else
    check_eq("t6_err",   32'(o_err[s3+277]),   32'd1);
    check_eq("t6_ready", 32'(o_ready[s3+277]), 32'd0);
`endif
    check_eq("t6_botao", 32'(o_botao[s3+300]), 32'h3);

    // Random frames with line noise; some episodes are cut short by reset.
    for (int ep = 0; ep < 6; ep++) begin
      clear_line();
      p = 5 + $urandom_range(0, 20);
      nfr = $urandom_range(2, 4);
      for (int f = 0; f < nfr; f++) begin
        rcode = NB'($urandom_range(0, 7));
        put_frame(p, rcode, pe);
        for (int n = 0; n < $urandom_range(0, 6); n++) begin
          q = p + 5 + $urandom_range(0, pe - p - 6);
          line[q] = ~line[q];
        end
        for (int n = 0; n < $urandom_range(0, 2); n++) line[pe + $urandom_range(0, 60)] = 1'b0;
        p = pe + 150 + $urandom_range(0, 60);
      end
      len = p + 20;
      if ($urandom_range(0, 2) == 0) begin
        cut = $urandom_range(50, len - 1);
        run_episode(cut, 1'b1);
      end else begin
        run_episode(len, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
